// File: rtl/supernova_vmem_adapter.sv
// supernova_vmem_adapter: splits one VLEN-wide vector load/store into BEATS
// sequential XLEN-wide beats on the scalar data bus and reassembles load data
// into a single VLEN-wide completion. Misaligned bases and bus errors are
// reported back to the vector unit with vmem_err on the completion pulse.
module supernova_vmem_adapter #(
    parameter int VLEN = 256,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vmem_req,
    input  logic            vmem_we,
    input  logic [XLEN-1:0] vmem_addr,
    input  logic [VLEN-1:0] vmem_wdata,
    output logic [VLEN-1:0] vmem_rdata,
    output logic            vmem_ack,
    output logic            vmem_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack,
    input  logic            bus_err,
    output logic [63:0]     xfer_count
);

    localparam int BEATS  = VLEN / XLEN;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(XLEN / 8);
    localparam logic [XLEN-1:0]   STEP      = XLEN'(XLEN / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT,
        ST_RESP
    } state_t;

    state_t            state_q,      state_d;
    logic [BEAT_W-1:0] beat_q,       beat_d;
    logic [VLEN-1:0]   wdata_q,      wdata_d;
    logic [VLEN-1:0]   rdata_q,      rdata_d;
    logic              bus_req_q,    bus_req_d;
    logic              bus_we_q,     bus_we_d;
    logic [XLEN-1:0]   bus_addr_q,   bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q,  bus_wdata_d;
    logic              vmem_ack_q,   vmem_ack_d;
    logic              vmem_err_q,   vmem_err_d;
    logic [63:0]       xfer_count_q, xfer_count_d;

    logic [BEAT_W-1:0] beat_inc;
    assign beat_inc = beat_q + BEAT_W'(1);

    // Next-state and next-output computation for the beat sequencer.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d      = state_q;
        beat_d       = beat_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        vmem_ack_d   = 1'b0;
        vmem_err_d   = vmem_err_q;
        xfer_count_d = xfer_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (vmem_req) begin
                    wdata_d = vmem_wdata;
                    beat_d  = '0;
                    // Start from zero so stores and aborted loads return clean data.
                    rdata_d = '0;
                    if (vmem_addr[OFF_W-1:0] != '0) begin
                        // Misaligned base: complete with an error, no bus traffic.
                        state_d    = ST_RESP;
                        vmem_ack_d = 1'b1;
                        vmem_err_d = 1'b1;
                    end else begin
                        state_d     = ST_BEAT;
                        bus_req_d   = 1'b1;
                        bus_we_d    = vmem_we;
                        bus_addr_d  = vmem_addr;
                        bus_wdata_d = vmem_wdata[XLEN-1:0];
                    end
                end
            end
            ST_BEAT: begin
                // Responses only count while a beat is actually outstanding.
                if (bus_req_q) begin
                    if (bus_err) begin
                        // Error wins over a simultaneous ack; remaining beats are dropped.
                        state_d    = ST_RESP;
                        bus_req_d  = 1'b0;
                        bus_we_d   = 1'b0;
                        vmem_ack_d = 1'b1;
                        vmem_err_d = 1'b1;
                    end else if (bus_ack) begin
                        if (!bus_we_q) begin
                            rdata_d[beat_q*XLEN +: XLEN] = bus_rdata;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_d    = ST_RESP;
                            bus_req_d  = 1'b0;
                            bus_we_d   = 1'b0;
                            vmem_ack_d = 1'b1;
                            vmem_err_d = 1'b0;
                        end else begin
                            // Address wraps modulo 2^XLEN by construction.
                            beat_d      = beat_inc;
                            bus_addr_d  = bus_addr_q + STEP;
                            bus_wdata_d = wdata_q[beat_inc*XLEN +: XLEN];
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Count every completion, successful or not, as the ack is issued.
        if (vmem_ack_d) begin
            xfer_count_d = xfer_count_q + 64'd1;
        end
    end

    // State and registered outputs; reset aborts any access without a completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            vmem_ack_q   <= 1'b0;
            vmem_err_q   <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            beat_q       <= beat_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            vmem_ack_q   <= vmem_ack_d;
            vmem_err_q   <= vmem_err_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign vmem_rdata = rdata_q;
    assign vmem_ack   = vmem_ack_q;
    assign vmem_err   = vmem_err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_supernova_vmem_adapter.sv
// Testbench for supernova_vmem_adapter: table of directed accesses with a
// per-beat bus responder, plus hand-written reset and back-to-back sequences.
module tb_supernova_vmem_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vmem_req = 1'b0;
    logic         vmem_we = 1'b0;
    logic [63:0]  vmem_addr = '0;
    logic [255:0] vmem_wdata = '0;
    logic [255:0] vmem_rdata;
    logic         vmem_ack;
    logic         vmem_err;
    logic         bus_req;
    logic         bus_we;
    logic [63:0]  bus_addr;
    logic [63:0]  bus_wdata;
    logic [63:0]  bus_rdata = '0;
    logic         bus_ack = 1'b0;
    logic         bus_err = 1'b0;
    logic [63:0]  xfer_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_count = '0;

    supernova_vmem_adapter #(.VLEN(256), .XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .vmem_req   (vmem_req),
        .vmem_we    (vmem_we),
        .vmem_addr  (vmem_addr),
        .vmem_wdata (vmem_wdata),
        .vmem_rdata (vmem_rdata),
        .vmem_ack   (vmem_ack),
        .vmem_err   (vmem_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         we;
        logic [63:0]  addr;
        logic [255:0] wdata;
        int           wait_cycles;  // cycles each beat waits before its response
        int           err_beat;     // beat that gets bus_err, -1 for none
        bit           err_with_ack; // raise bus_ack together with bus_err
        int           exp_beats;    // beats that receive a bus response
        int           exp_cycle;    // cycle of vmem_ack, request sampled at cycle 0
        logic         exp_err;
        logic [255:0] exp_rdata;
    } vec_t;

    logic [63:0] rd_beat [4];
    vec_t vecs [8];

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [63:0] addr,
                                input logic [255:0] wdata, input int wait_cycles, input int err_beat,
                                input bit err_with_ack, input int exp_beats, input int exp_cycle,
                                input logic exp_err, input logic [255:0] exp_rdata);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
        v.wait_cycles = wait_cycles; v.err_beat = err_beat; v.err_with_ack = err_with_ack;
        v.exp_beats = exp_beats; v.exp_cycle = exp_cycle; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Issue one access, answer its beats, and check beats and completion.
    task automatic run_access(input vec_t v);
        int  cyc;
        int  beat;
        int  wait_cnt;
        bit  done;
        logic [63:0] exp_addr;
        vmem_req   = 1'b1;
        vmem_we    = v.we;
        vmem_addr  = v.addr;
        vmem_wdata = v.wdata;
        tick();
        vmem_req = 1'b0;
        cyc = 1; beat = 0; wait_cnt = 0; done = 1'b0;
        while (!done && cyc <= 40) begin
            bus_ack = 1'b0;
            bus_err = 1'b0;
            if (vmem_ack) begin
                done = 1'b1;
                check({v.name, " ack cycle"}, 256'(cyc), 256'(v.exp_cycle));
                check({v.name, " err"}, 256'(vmem_err), 256'(v.exp_err));
                check({v.name, " rdata"}, vmem_rdata, v.exp_rdata);
                check({v.name, " bus_req low at ack"}, 256'(bus_req), 256'(0));
            end else if (bus_req) begin
                exp_addr = v.addr + 64'(beat) * 64'd8;
                check({v.name, " bus_addr"}, 256'(bus_addr), 256'(exp_addr));
                check({v.name, " bus_wdata"}, 256'(bus_wdata), 256'(v.wdata[beat*64 +: 64]));
                check({v.name, " bus_we"}, 256'(bus_we), 256'(v.we));
                if (wait_cnt == v.wait_cycles) begin
                    if (beat == v.err_beat) begin
                        bus_err   = 1'b1;
                        bus_ack   = v.err_with_ack;
                        bus_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
                    end else begin
                        bus_ack   = 1'b1;
                        bus_rdata = (beat < 4) ? rd_beat[beat] : 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                    beat++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        bus_ack = 1'b0;
        bus_err = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no vmem_ack within 40 cycles", v.name);
        end
        check({v.name, " beats issued"}, 256'(beat), 256'(v.exp_beats));
        exp_count = exp_count + 64'd1;
        tick();
        check({v.name, " ack is one pulse"}, 256'(vmem_ack), 256'(0));
        check({v.name, " xfer_count"}, 256'(xfer_count), 256'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_cycles [$];

        rd_beat[0] = 64'hAAAA_0000_0000_0000;
        rd_beat[1] = 64'hBBBB_0000_0000_0001;
        rd_beat[2] = 64'hCCCC_0000_0000_0002;
        rd_beat[3] = 64'hDDDD_0000_0000_0003;

        vecs[0] = mk("load 0x1000", 1'b0, 64'h1000, '0, 0, -1, 1'b0, 4, 5, 1'b0,
                     256'hDDDD000000000003_CCCC000000000002_BBBB000000000001_AAAA000000000000);
        vecs[1] = mk("store 0x2000 wait2", 1'b1, 64'h2000,
                     256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                     2, -1, 1'b0, 4, 13, 1'b0, '0);
        vecs[2] = mk("misaligned load", 1'b0, 64'h1004, '0, 0, -1, 1'b0, 0, 1, 1'b1, '0);
        vecs[3] = mk("load err beat2", 1'b0, 64'h3000, '0, 0, 2, 1'b0, 3, 4, 1'b1,
                     256'h0000000000000000_0000000000000000_BBBB000000000001_AAAA000000000000);
        vecs[4] = mk("load err+ack beat2", 1'b0, 64'h3000, '0, 0, 2, 1'b1, 3, 4, 1'b1,
                     256'h0000000000000000_0000000000000000_BBBB000000000001_AAAA000000000000);
        vecs[5] = mk("load wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, '0, 0, -1, 1'b0, 4, 5, 1'b0,
                     256'hDDDD000000000003_CCCC000000000002_BBBB000000000001_AAAA000000000000);
        vecs[6] = mk("store err beat0 wait1", 1'b1, 64'h4000,
                     256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555,
                     1, 0, 1'b0, 1, 3, 1'b1, '0);
        vecs[7] = mk("misaligned store", 1'b1, 64'h2002,
                     256'h1, 0, -1, 1'b0, 0, 1, 1'b1, '0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset bus_req", 256'(bus_req), 256'(0));
        check("reset bus_we", 256'(bus_we), 256'(0));
        check("reset bus_addr", 256'(bus_addr), 256'(0));
        check("reset bus_wdata", 256'(bus_wdata), 256'(0));
        check("reset vmem_ack", 256'(vmem_ack), 256'(0));
        check("reset vmem_err", 256'(vmem_err), 256'(0));
        check("reset vmem_rdata", vmem_rdata, 256'(0));
        check("reset xfer_count", 256'(xfer_count), 256'(0));
        rst = 1'b0;
        tick();

        // Reset asserted during beat 1 of a load aborts it without a completion.
        vmem_req  = 1'b1;
        vmem_we   = 1'b0;
        vmem_addr = 64'h1000;
        tick();
        vmem_req  = 1'b0;
        check("abort beat0 bus_req", 256'(bus_req), 256'(1));
        bus_ack   = 1'b1;
        bus_rdata = rd_beat[0];
        tick();
        bus_ack = 1'b0;
        check("abort beat1 bus_req", 256'(bus_req), 256'(1));
        check("abort beat1 bus_addr", 256'(bus_addr), 256'(64'h1008));
        rst = 1'b1;
        #1;
        check("abort async bus_req drop", 256'(bus_req), 256'(0));
        check("abort async bus_addr", 256'(bus_addr), 256'(0));
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("abort no ack", 256'(vmem_ack), 256'(0));
            check("abort no bus_req", 256'(bus_req), 256'(0));
            tick();
        end
        check("abort xfer_count", 256'(xfer_count), 256'(0));

        // Table-driven accesses; the first also shows a clean restart after reset.
        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i]);
        end

        // Back-to-back: vmem_req held high across the first completion.
        vmem_req  = 1'b1;
        vmem_we   = 1'b0;
        vmem_addr = 64'h5000;
        tick();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            bus_ack = 1'b0;
            if (cyc == 7) vmem_req = 1'b0;
            if (cyc == 6) check("b2b idle gap bus_req", 256'(bus_req), 256'(0));
            if (vmem_ack) ack_cycles.push_back(cyc);
            if (bus_req) begin
                bus_ack   = 1'b1;
                bus_rdata = rd_beat[0];
            end
            tick();
        end
        bus_ack = 1'b0;
        check("b2b ack count", 256'(ack_cycles.size()), 256'(2));
        if (ack_cycles.size() == 2) begin
            check("b2b first ack cycle", 256'(ack_cycles[0]), 256'(5));
            check("b2b second ack cycle", 256'(ack_cycles[1]), 256'(11));
        end
        exp_count = exp_count + 64'd2;
        check("final xfer_count", 256'(xfer_count), 256'(exp_count));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/supernova_vmem_adapter.md
Name: supernova_vmem_adapter

Overview:
- Sits directly downstream of the vector execution unit's memory port. It converts one VLEN-wide vector load or store into a sequence of XLEN-wide beats on the scalar data bus.
- Read beats are reassembled into a VLEN-wide result, then a single completion is returned upstream.
- Alignment errors and bus errors are reported back to the vector unit.

Parameters:
- VLEN, 256, vector register width in bits; must be a multiple of XLEN.
- XLEN, 64, bus data width and address width in bits.
- BEATS, VLEN/XLEN, number of bus beats per vector access. Derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- vmem_req  in  1  upstream request; sampled only in IDLE
- vmem_we  in  1  1 = store, 0 = load; sampled with vmem_req
- vmem_addr  in  XLEN  vector base byte address
- vmem_wdata  in  VLEN  store data
- vmem_rdata  out  VLEN  load data; valid while vmem_ack=1
- vmem_ack  out  1  one-cycle completion pulse
- vmem_err  out  1  error flag; valid only while vmem_ack=1
- bus_req  out  1  beat request; held until bus_ack or bus_err
- bus_we  out  1  beat write enable
- bus_addr  out  XLEN  beat byte address
- bus_wdata  out  XLEN  beat write data
- bus_rdata  in  XLEN  beat read data; valid with bus_ack
- bus_ack  in  1  beat complete
- bus_err  in  1  beat failed; takes priority over bus_ack in the same cycle
- xfer_count  out  64  number of completed vector accesses, counting both success and error

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - State goes to IDLE; beat counter to 0.
  - All outputs go to 0: bus_req, bus_we, bus_addr, bus_wdata, vmem_ack, vmem_err, vmem_rdata, xfer_count.
  - Reset mid-transfer drops bus_req in the same cycle. No completion is ever issued for the aborted access.
- States: IDLE, BEAT, RESP.
- IDLE, with vmem_req=1:
  - Latch we, addr, wdata; clear the beat counter.
  - If addr[$clog2(XLEN/8)-1:0] != 0 (misaligned), go to RESP with err=1 and issue no bus traffic.
  - Otherwise go to BEAT.
- BEAT:
  - bus_req=1, bus_we=latched we.
  - bus_addr = base + i*(XLEN/8) for beat i.
  - bus_wdata = wdata[i*XLEN +: XLEN].
  - Outputs are registered and stable until the beat completes.
- On bus_ack (and bus_err=0):
  - For a load, capture bus_rdata into rdata[i*XLEN +: XLEN].
  - If i == BEATS-1, go to RESP with err=0 and drop bus_req. Otherwise increment i; bus_req stays high and the address/data advance on the next cycle.
- On bus_err:
  - Go to RESP immediately with err=1 and drop bus_req.
  - The remaining beats are not issued.
  - rdata holds the beats captured before the error; the beat that reported the error is not captured.
- RESP (exactly one cycle):
  - vmem_ack=1, vmem_err=err, vmem_rdata=assembled data. For stores, vmem_rdata is 0.
  - xfer_count increments by 1, wrapping at 2^64.
  - Next state is IDLE.
- Upstream handshake:
  - vmem_req is ignored outside IDLE.
  - The requester must drop vmem_req by the cycle after vmem_ack; a req still high in IDLE is treated as a new access.
- Latency with a zero-wait bus (bus_ack in the same cycle as bus_req):
  - Request sampled at cycle 0.
  - Beats occupy cycles 1..BEATS.
  - vmem_ack at cycle BEATS+1 (cycle 5 at the defaults).
  - A misaligned request acks at cycle 1.
- Address arithmetic is modulo 2^XLEN; a beat address that wraps past the top of memory wraps silently.
- A bus_ack or bus_err arriving while bus_req=0 is ignored.

Test Plan:
- Aligned load, addr=0x1000, zero-wait bus:
  - Response: bus_addr = 0x1000, 0x1008, 0x1010, 0x1018 on cycles 1-4; vmem_ack on cycle 5; vmem_rdata = {beat3, beat2, beat1, beat0}; err=0; xfer_count=1.
- Store, addr=0x2000, wdata = 256'h4444..._3333..._2222..._1111..., bus_ack delayed 2 cycles per beat:
  - Response: bus_wdata is 0x1111... first and 0x4444... last; each beat is held stable while waiting; bus_we=1 throughout; a single ack at the end.
- Misaligned load, addr=0x1004:
  - Response: no bus_req ever; vmem_ack=1 with vmem_err=1 at cycle 1.
- bus_err on beat 2 of a load:
  - Response: beat 3 is never requested; vmem_ack with err=1; rdata[127:0] holds beats 0-1.
  - bus_err and bus_ack asserted together on a beat must be treated as err.
- rst asserted during beat 1:
  - Response: bus_req drops asynchronously; no vmem_ack; xfer_count unchanged.
  - A new request after reset completes normally.
- Base address 0xFFFF_FFFF_FFFF_FFF0, load:
  - Response: beat addresses ...FFF0, ...FFF8, 0x0, 0x8.
  - Back-to-back requests with vmem_req held high produce two acks, with one IDLE cycle between them.
